// File: rtl/lock_chamber_ctrl.sv
// Canal lock chamber controller: sequences a gondola through the chamber,
// interlocks the doors against the water level, and drives the status LEDs.
module lock_chamber_ctrl #(
    parameter int unsigned BOAT_DELAY = 10,
    parameter int unsigned LEVEL_MAX  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       outer_gondola_arrival_sw,
    input  logic       inner_gondola_arrival_sw,
    input  logic       outer_door_sw,
    input  logic       inner_door_sw,
    input  logic       inc_water_level,
    input  logic       dec_water_level,
    output logic       outer_gondola_led,
    output logic       inner_gondola_led,
    output logic       outer_door_openable_led,
    output logic       inner_door_openable_led,
    output logic       chamber_occupied,
    output logic [3:0] water_level,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_ARRIVE     = 3'd1,
        S_WAIT_ENTRY = 3'd2,
        S_ENTER      = 3'd3,
        S_IN_CHAMBER = 3'd4,
        S_DEPART     = 3'd5
    } state_t;

    typedef enum logic {
        SIDE_OUTER = 1'b0,
        SIDE_INNER = 1'b1
    } side_t;

    localparam logic [7:0] CNT_LOAD = 8'(BOAT_DELAY - 1);
    localparam logic [3:0] LVL_TOP  = 4'(LEVEL_MAX);

    state_t     state_q, state_d;
    side_t      side_q, side_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] level_q, level_d;
    logic [3:0] sw_prev_q;
    logic       primed_q;
    logic       og_led_q, ig_led_q, oo_led_q, io_led_q, occ_q;
    logic       og_led_d, ig_led_d, oo_led_d, io_led_d, occ_d;

    logic [3:0] sw_now;
    logic [3:0] rise;
    logic       rise_oa, rise_ia, rise_od, rise_id;
    logic       outer_match, inner_match;
    logic       outer_match_d, inner_match_d;

    assign sw_now = {outer_gondola_arrival_sw, inner_gondola_arrival_sw,
                     outer_door_sw, inner_door_sw};

    // No edge is reported on the first clock after reset, so a switch that
    // was already high while reset was asserted is not seen as a request.
    assign rise    = primed_q ? (sw_now & ~sw_prev_q) : '0;
    assign rise_oa = rise[3];
    assign rise_ia = rise[2];
    assign rise_od = rise[1];
    assign rise_id = rise[0];

    assign outer_match = (level_q == '0);
    assign inner_match = (level_q == LVL_TOP);

    always_comb begin
        state_d = state_q;
        side_d  = side_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (rise_oa) begin
                    state_d = S_ARRIVE;
                    side_d  = SIDE_OUTER;
                    cnt_d   = CNT_LOAD;
                end else if (rise_ia) begin
                    state_d = S_ARRIVE;
                    side_d  = SIDE_INNER;
                    cnt_d   = CNT_LOAD;
                end
            end
            S_ARRIVE: begin
                if (cnt_q == '0) state_d = S_WAIT_ENTRY;
                else             cnt_d   = cnt_q - 8'd1;
            end
            S_WAIT_ENTRY: begin
                if ((side_q == SIDE_OUTER && rise_od && outer_match) ||
                    (side_q == SIDE_INNER && rise_id && inner_match)) begin
                    state_d = S_ENTER;
                    cnt_d   = CNT_LOAD;
                end
            end
            S_ENTER: begin
                if (cnt_q == '0) state_d = S_IN_CHAMBER;
                else             cnt_d   = cnt_q - 8'd1;
            end
            S_IN_CHAMBER: begin
                if ((side_q == SIDE_OUTER && rise_id && inner_match) ||
                    (side_q == SIDE_INNER && rise_od && outer_match)) begin
                    state_d = S_DEPART;
                    cnt_d   = CNT_LOAD;
                end
            end
            S_DEPART: begin
                if (cnt_q == '0) state_d = S_IDLE;
                else             cnt_d   = cnt_q - 8'd1;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // The level is frozen while a door is open for a gondola passing through.
    always_comb begin
        level_d = level_q;
        if (state_q != S_ENTER && state_q != S_DEPART) begin
            if (inc_water_level && !dec_water_level && level_q < LVL_TOP)
                level_d = level_q + 4'd1;
            else if (dec_water_level && !inc_water_level && level_q != '0)
                level_d = level_q - 4'd1;
        end
    end

    // LEDs are derived from next-state values so the registered outputs are
    // consistent with the registered state and level in the same cycle.
    always_comb begin
        outer_match_d = (level_d == '0);
        inner_match_d = (level_d == LVL_TOP);
        og_led_d = (state_d == S_WAIT_ENTRY) && (side_d == SIDE_OUTER);
        ig_led_d = (state_d == S_WAIT_ENTRY) && (side_d == SIDE_INNER);
        occ_d    = (state_d == S_IN_CHAMBER);
        oo_led_d = outer_match_d &&
                   ((state_d == S_WAIT_ENTRY && side_d == SIDE_OUTER) ||
                    (state_d == S_IN_CHAMBER && side_d == SIDE_INNER));
        io_led_d = inner_match_d &&
                   ((state_d == S_WAIT_ENTRY && side_d == SIDE_INNER) ||
                    (state_d == S_IN_CHAMBER && side_d == SIDE_OUTER));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            side_q    <= SIDE_OUTER;
            cnt_q     <= '0;
            level_q   <= '0;
            sw_prev_q <= '0;
            primed_q  <= 1'b0;
            og_led_q  <= 1'b0;
            ig_led_q  <= 1'b0;
            oo_led_q  <= 1'b0;
            io_led_q  <= 1'b0;
            occ_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            side_q    <= side_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            sw_prev_q <= sw_now;
            primed_q  <= 1'b1;
            og_led_q  <= og_led_d;
            ig_led_q  <= ig_led_d;
            oo_led_q  <= oo_led_d;
            io_led_q  <= io_led_d;
            occ_q     <= occ_d;
        end
    end

    assign outer_gondola_led       = og_led_q;
    assign inner_gondola_led       = ig_led_q;
    assign outer_door_openable_led = oo_led_q;
    assign inner_door_openable_led = io_led_q;
    assign chamber_occupied        = occ_q;
    assign water_level             = level_q;
    assign state                   = state_q;

endmodule

// File: tb/tb_lock_chamber_ctrl.sv
// Self-checking bench for lock_chamber_ctrl: table-driven level checks plus
// hand-written transit, interlock and reset sequences through a scoreboard.
module tb_lock_chamber_ctrl;

    localparam logic [5:0] I_OA  = 6'b100000;
    localparam logic [5:0] I_IA  = 6'b010000;
    localparam logic [5:0] I_OD  = 6'b001000;
    localparam logic [5:0] I_ID  = 6'b000100;
    localparam logic [5:0] I_INC = 6'b000010;
    localparam logic [5:0] I_DEC = 6'b000001;
    localparam logic [5:0] I_NONE = 6'b000000;

    // LED vector order: {outer_gondola, inner_gondola, outer_open, inner_open, occupied}
    localparam logic [4:0] L_OG  = 5'b10000;
    localparam logic [4:0] L_IG  = 5'b01000;
    localparam logic [4:0] L_OO  = 5'b00100;
    localparam logic [4:0] L_IO  = 5'b00010;
    localparam logic [4:0] L_OCC = 5'b00001;
    localparam logic [4:0] L_NONE = 5'b00000;

    typedef struct packed {
        logic [2:0] st;
        logic [3:0] lvl;
        logic [4:0] leds;
    } exp_t;

    typedef struct {
        logic [5:0] in;
        exp_t       e;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       oa = 1'b0, ia = 1'b0, od = 1'b0, id = 1'b0, inc = 1'b0, dec = 1'b0;
    logic       og_led, ig_led, oo_led, io_led, occ;
    logic [3:0] water_level;
    logic [2:0] state;

    int tests = 0;
    int fails = 0;

    exp_t  exp_q[$];
    string name_q[$];
    string phase = "init";
    vec_t  tbl[$];

    lock_chamber_ctrl #(.BOAT_DELAY(10), .LEVEL_MAX(8)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .outer_gondola_arrival_sw (oa),
        .inner_gondola_arrival_sw (ia),
        .outer_door_sw            (od),
        .inner_door_sw            (id),
        .inc_water_level          (inc),
        .dec_water_level          (dec),
        .outer_gondola_led        (og_led),
        .inner_gondola_led        (ig_led),
        .outer_door_openable_led  (oo_led),
        .inner_door_openable_led  (io_led),
        .chamber_occupied         (occ),
        .water_level              (water_level),
        .state                    (state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    function automatic exp_t mk(input logic [2:0] st, input int lvl, input logic [4:0] leds);
        exp_t e;
        e.st   = st;
        e.lvl  = 4'(lvl);
        e.leds = leds;
        return e;
    endfunction

    function automatic exp_t actual();
        exp_t a;
        a.st   = state;
        a.lvl  = water_level;
        a.leds = {og_led, ig_led, oo_led, io_led, occ};
        return a;
    endfunction

    task automatic compare(input string name, input exp_t act, input exp_t e);
        tests++;
        if (act !== e) begin
            fails++;
            $display("FAIL %s: got state=%0d level=%0d leds=%b, expected state=%0d level=%0d leds=%b",
                     name, act.st, act.lvl, act.leds, e.st, e.lvl, e.leds);
        end
    endtask

    // Scoreboard: each driven cycle's expectation is popped just after the edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            compare(name_q.pop_front(), actual(), exp_q.pop_front());
        end
    end

    task automatic cyc(input logic [5:0] in, input exp_t e);
        @(posedge clk);
        #2;
        {oa, ia, od, id, inc, dec} = in;
        exp_q.push_back(e);
        name_q.push_back(phase);
    endtask

    task automatic drain();
        @(posedge clk);
        #2;
    endtask

    initial begin
        // Level table: saturate up, step down, hold with both, saturate down.
        for (int i = 1; i <= 20; i++) tbl.push_back('{I_INC, mk(3'd0, (i < 8) ? i : 8, L_NONE)});
        for (int i = 1; i <= 3; i++)  tbl.push_back('{I_DEC, mk(3'd0, 8 - i, L_NONE)});
        for (int i = 1; i <= 5; i++)  tbl.push_back('{I_INC | I_DEC, mk(3'd0, 5, L_NONE)});
        for (int i = 1; i <= 20; i++) tbl.push_back('{I_DEC, mk(3'd0, (5 - i > 0) ? 5 - i : 0, L_NONE)});

        // Reset state, with the outer arrival switch held high through reset.
        oa = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        phase = "reset_state";
        compare(phase, actual(), mk(3'd0, 0, L_NONE));
        #1;
        reset = 1'b0;
        phase = "sw_high_at_reset_release";
        cyc(I_OA, mk(3'd0, 0, L_NONE));
        cyc(I_OA, mk(3'd0, 0, L_NONE));
        cyc(I_NONE, mk(3'd0, 0, L_NONE));

        phase = "level_table";
        foreach (tbl[k]) cyc(tbl[k].in, tbl[k].e);

        phase = "outer_arrive";
        cyc(I_OA, mk(3'd1, 0, L_NONE));
        repeat (9) cyc(I_NONE, mk(3'd1, 0, L_NONE));
        phase = "outer_wait_entry";
        cyc(I_NONE, mk(3'd2, 0, L_OG | L_OO));
        phase = "outer_enter_frozen";
        cyc(I_OD, mk(3'd3, 0, L_NONE));
        repeat (9) cyc(I_INC, mk(3'd3, 0, L_NONE));
        phase = "outer_in_chamber";
        cyc(I_INC, mk(3'd4, 0, L_OCC));
        phase = "outer_raise_level";
        for (int i = 1; i <= 8; i++) cyc(I_INC, mk(3'd4, i, L_OCC | ((i == 8) ? L_IO : L_NONE)));
        phase = "outer_depart";
        cyc(I_ID, mk(3'd5, 8, L_NONE));
        repeat (9) cyc(I_DEC, mk(3'd5, 8, L_NONE));
        phase = "outer_back_idle";
        cyc(I_DEC, mk(3'd0, 8, L_NONE));

        phase = "inner_arrive";
        cyc(I_IA, mk(3'd1, 8, L_NONE));
        repeat (9) cyc(I_NONE, mk(3'd1, 8, L_NONE));
        phase = "inner_wait_entry";
        cyc(I_NONE, mk(3'd2, 8, L_IG | L_IO));
        phase = "inner_wrong_door_ignored";
        cyc(I_OD, mk(3'd2, 8, L_IG | L_IO));
        phase = "inner_enter";
        cyc(I_ID, mk(3'd3, 8, L_NONE));
        repeat (9) cyc(I_NONE, mk(3'd3, 8, L_NONE));
        cyc(I_NONE, mk(3'd4, 8, L_OCC));
        phase = "inner_lower_level";
        for (int i = 1; i <= 8; i++) cyc(I_DEC, mk(3'd4, 8 - i, L_OCC | ((i == 8) ? L_OO : L_NONE)));
        phase = "inner_depart";
        cyc(I_OD, mk(3'd5, 0, L_NONE));
        repeat (9) cyc(I_NONE, mk(3'd5, 0, L_NONE));
        cyc(I_NONE, mk(3'd0, 0, L_NONE));

        phase = "simultaneous_arrival";
        cyc(I_OA | I_IA, mk(3'd1, 0, L_NONE));
        repeat (9) cyc(I_NONE, mk(3'd1, 0, L_NONE));
        cyc(I_NONE, mk(3'd2, 0, L_OG | L_OO));

        phase = "interlock";
        for (int i = 1; i <= 3; i++) cyc(I_INC, mk(3'd2, i, L_OG));
        cyc(I_OD, mk(3'd2, 3, L_OG));
        cyc(I_NONE, mk(3'd2, 3, L_OG));
        cyc(I_ID, mk(3'd2, 3, L_OG));
        for (int i = 1; i <= 3; i++) cyc(I_DEC, mk(3'd2, 3 - i, L_OG | ((i == 3) ? L_OO : L_NONE)));
        phase = "enter_before_reset";
        cyc(I_OD, mk(3'd3, 0, L_NONE));
        repeat (4) cyc(I_NONE, mk(3'd3, 0, L_NONE));
        drain();

        // Asynchronous reset mid-ENTER: outputs clear without a clock edge.
        phase = "async_reset_in_enter";
        compare("enter_before_async_reset", actual(), mk(3'd3, 0, L_NONE));
        reset = 1'b1;
        #1;
        compare(phase, actual(), mk(3'd0, 0, L_NONE));
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        phase = "after_reset_idle";
        cyc(I_NONE, mk(3'd0, 0, L_NONE));
        cyc(I_NONE, mk(3'd0, 0, L_NONE));
        phase = "after_reset_arrival";
        cyc(I_IA, mk(3'd1, 0, L_NONE));
        cyc(I_NONE, mk(3'd1, 0, L_NONE));
        drain();

        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lock_chamber_ctrl.md
LOCK_CHAMBER_CTRL -- requirements
Module: lock_chamber_ctrl

Interface
REQ-001 SHALL have parameter BOAT_DELAY, default 10, giving cycles for a gondola to arrive, enter or depart (legal 1..255).
REQ-002 SHALL have parameter LEVEL_MAX, default 8, giving the water level equal to the inner side (legal 1..15).
REQ-003 SHALL have port clk  in  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port outer_gondola_arrival_sw  in  1  level switch; a rising edge requests arrival at the outer side.
REQ-006 SHALL have port inner_gondola_arrival_sw  in  1  level switch; a rising edge requests arrival at the inner side.
REQ-007 SHALL have port outer_door_sw  in  1  level switch; a rising edge is an open request for the outer door.
REQ-008 SHALL have port inner_door_sw  in  1  level switch; a rising edge is an open request for the inner door.
REQ-009 SHALL have port inc_water_level  in  1  raise the level by 1 on each cycle it is high.
REQ-010 SHALL have port dec_water_level  in  1  lower the level by 1 on each cycle it is high.
REQ-011 SHALL have port outer_gondola_led  out  1  gondola waiting at the outer door.
REQ-012 SHALL have port inner_gondola_led  out  1  gondola waiting at the inner door.
REQ-013 SHALL have port outer_door_openable_led  out  1  outer door may open now.
REQ-014 SHALL have port inner_door_openable_led  out  1  inner door may open now.
REQ-015 SHALL have port chamber_occupied  out  1  gondola inside the chamber.
REQ-016 SHALL have port water_level  out  4  current chamber level, 0..LEVEL_MAX.
REQ-017 SHALL have port state  out  3  FSM code: IDLE=0, ARRIVE=1, WAIT_ENTRY=2, ENTER=3, IN_CHAMBER=4, DEPART=5.

Function
REQ-018 SHALL detect a rising edge on any _sw input as the input high at a clk edge after being low at the previous clk edge, using a registered copy of the previous value.
REQ-019 SHALL register all outputs and hold them constant between clk edges.
REQ-020 SHALL move IDLE->ARRIVE on an arrival edge, latching side=OUTER or INNER; if both edges occur together, OUTER SHALL win and the inner edge SHALL be dropped.
REQ-021 SHALL ignore arrival edges in every state other than IDLE.
REQ-022 SHALL, in ARRIVE, ENTER and DEPART, load a counter with BOAT_DELAY-1 on entry, decrement it each cycle, and take the exit transition on the edge where it reads 0, so each of these states lasts exactly BOAT_DELAY cycles.
REQ-023 SHALL use these transitions: ARRIVE->WAIT_ENTRY; ENTER->IN_CHAMBER; DEPART->IDLE.
REQ-024 SHALL define the outer door as matched when water_level==0 and the inner door as matched when water_level==LEVEL_MAX.
REQ-025 SHALL, in WAIT_ENTRY, drive the openable LED only for the latched-side door, and only while that door is matched.
REQ-026 SHALL move WAIT_ENTRY->ENTER on that door's sw edge while it is matched; all other door edges SHALL be ignored.
REQ-027 SHALL, in IN_CHAMBER, drive the openable LED only for the opposite-side door while it is matched, and move IN_CHAMBER->DEPART on that door's edge.
REQ-028 SHALL never drive both openable LEDs high in the same cycle.
REQ-029 SHALL drive outer_gondola_led high only in WAIT_ENTRY with side=OUTER, and inner_gondola_led high only in WAIT_ENTRY with side=INNER.
REQ-030 SHALL drive chamber_occupied high in IN_CHAMBER only.
REQ-031 SHALL freeze water_level in ENTER and DEPART, when the doors are open.
REQ-032 SHALL otherwise update water_level each cycle: inc-only +1 saturating at LEVEL_MAX; dec-only -1 saturating at 0; inc and dec together, no change.

Reset
REQ-033 SHALL, while reset is high and asynchronously to clk, force state=IDLE, water_level=0, counter=0, side=OUTER, edge-detect registers=0 and all LEDs=0.
REQ-034 SHALL, on reset asserted mid-operation in any state, abandon the gondola and resume at IDLE on the first clk edge after reset falls.
REQ-035 SHALL NOT report a rising edge for an _sw input that is already high when reset falls.

Verification
REQ-036 SHALL verify outer transit: outer arrival edge at edge E -> state=2 and outer_gondola_led=1 at E+10; outer_door_sw edge -> ENTER for 10 cycles; 8 inc cycles -> water_level=8 and inner_door_openable_led=1; inner_door_sw edge -> DEPART, then IDLE after 10 cycles.
REQ-037 SHALL verify saturation: 20 cycles of inc -> water_level=8; then 20 cycles of dec -> water_level=0; inc and dec together for 5 cycles -> no change.
REQ-038 SHALL verify interlock: in WAIT_ENTRY with side=OUTER and water_level=3, outer_door_sw and inner_door_sw edges -> state stays 2 and both openable LEDs=0.
REQ-039 SHALL verify simultaneous arrival: both arrival edges in one cycle -> side=OUTER, and after 10 cycles outer_gondola_led=1 while inner_gondola_led=0.
REQ-040 SHALL verify reset in ENTER: at counter=4 with water_level=0, pulse reset -> state=0, water_level=0 and all LEDs=0 immediately, with no clk edge required.
REQ-041 SHALL verify inner transit: with water_level=8, inner arrival edge -> inner door openable in WAIT_ENTRY; after ENTER, 8 dec cycles -> outer_door_openable_led=1.
